// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: op encodings, FSM state encoding, op -> ALU-control mapping helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULDIV_OP_MULT  = 3'b000,
        MULDIV_OP_MULTU = 3'b001,
        MULDIV_OP_DIV   = 3'b010,
        MULDIV_OP_DIVU  = 3'b011,
        MULDIV_OP_MADD  = 3'b100,
        MULDIV_OP_MADDU = 3'b101,
        MULDIV_OP_MSUB  = 3'b110,
        MULDIV_OP_MSUBU = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Which datapath an op is steered to.
    typedef enum logic [1:0] {
        ALU_MUL = 2'd0,
        ALU_DIV = 2'd1,
        ALU_ACC = 2'd2
    } muldiv_alu_e;

    function automatic muldiv_alu_e op_to_alu(input logic [2:0] op);
        if (op[2])      return ALU_ACC;
        else if (op[1]) return ALU_DIV;
        else            return ALU_MUL;
    endfunction

    // Even encodings are the signed variants.
    function automatic logic op_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    // MSUB/MSUBU subtract the product from HI/LO.
    function automatic logic op_acc_sub(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, RADIX quotient bits per cycle.
// Latency: start sampled on an edge, done pulses XLEN/RADIX cycles later.
// Backpressure: none; abort kills the run and suppresses done.
// Ports: clk, resetn (sync, active low), abort, start, dividend, divisor -> done, quotient, remainder.
module muldiv_div_core #(
    parameter int XLEN  = 32,
    parameter int RADIX = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int STEPS = XLEN / RADIX;
    localparam int IW    = $clog2(STEPS + 1);

    logic            running;
    logic [IW-1:0]   iter;
    logic [XLEN-1:0] d_r, rem_r, quo_r, rem_n, quo_n;
    logic [XLEN:0]   sh;

    // One restoring step per radix bit: shift in the next dividend bit,
    // subtract the divisor if it fits. The partial remainder stays below
    // the divisor, so it always fits back into XLEN bits.
    always_comb begin
        rem_n = rem_r;
        quo_n = quo_r;
        sh    = '0;
        for (int i = 0; i < RADIX; i++) begin
            sh    = {rem_n, quo_n[XLEN-1]};
            quo_n = {quo_n[XLEN-2:0], 1'b0};
            if (sh >= {1'b0, d_r}) begin
                sh       = sh - {1'b0, d_r};
                quo_n[0] = 1'b1;
            end
            rem_n = sh[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            running <= 1'b0;
            done    <= 1'b0;
            iter    <= '0;
            d_r     <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                running <= 1'b0;
            end else if (start) begin
                running <= 1'b1;
                iter    <= IW'(STEPS);
                rem_r   <= '0;
                quo_r   <= dividend;
                d_r     <= divisor;
            end else if (running) begin
                rem_r <= rem_n;
                quo_r <= quo_n;
                iter  <= iter - 1'b1;
                if (iter == IW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle multiply/divide engine producing a {hi,lo} result with a one-cycle valid pulse.
// Latency: MUL MUL_LAT, DIV XLEN/DIV_RADIX+2 (2 on divide-by-zero), 1xx ops MUL_LAT+1 or 1 without MULDIV_ACC_EN.
// Backpressure: stall = busy & ~result_valid holds the pipeline; op_valid is ignored while busy; flush aborts.
// Ports: clk, resetn (sync, active low), flush, op_valid, op, srca, srcb, hilo_in
//        -> busy, stall, result_valid, hilo_out, div_zero.
// Config: define MULDIV_ACC_EN to make ops 1xx MADD/MADDU/MSUB/MSUBU; otherwise they pass hilo_in through.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_LAT   = 3,
    parameter int DIV_RADIX = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   srca,
    input  logic [XLEN-1:0]   srcb,
    input  logic [2*XLEN-1:0] hilo_in,
    output logic              busy,
    output logic              stall,
    output logic              result_valid,
    output logic [2*XLEN-1:0] hilo_out,
    output logic              div_zero
);

    localparam int CW = 4;

    muldiv_state_e     state, state_n;
    logic [CW-1:0]     cnt, cnt_init;
    logic [2:0]        op_l;
    logic [XLEN-1:0]   a_l, b_l;
    logic [2*XLEN-1:0] hilo_l;
    logic              dz_r;
    logic [2*XLEN-1:0] pipe [MUL_LAT];

    logic accept;
    assign accept = op_valid && (state == ST_IDLE) && !flush;

    // Multiplier sits on the request operands so the product enters the
    // register chain on the accept edge; MUL_LAT edges later it is in hilo_out.
    logic              m_sgn, ma_neg, mb_neg;
    logic [XLEN-1:0]   ma_mag, mb_mag;
    logic [2*XLEN-1:0] prod_mag, prod;

    always_comb begin
        m_sgn    = op_signed(op);
        ma_neg   = m_sgn & srca[XLEN-1];
        mb_neg   = m_sgn & srcb[XLEN-1];
        ma_mag   = ma_neg ? -srca : srca;
        mb_mag   = mb_neg ? -srcb : srcb;
        prod_mag = {{XLEN{1'b0}}, ma_mag} * {{XLEN{1'b0}}, mb_mag};
        prod     = (ma_neg ^ mb_neg) ? -prod_mag : prod_mag;
    end

    // Divide works on magnitudes of the latched operands.
    logic            d_sgn, da_neg, db_neg, div_by_zero;
    logic [XLEN-1:0] da_mag, db_mag, q_mag, r_mag, q_fix, r_fix;
    logic            core_start, core_done, fix_now, mul_last;

    always_comb begin
        d_sgn       = op_signed(op_l);
        da_neg      = d_sgn & a_l[XLEN-1];
        db_neg      = d_sgn & b_l[XLEN-1];
        da_mag      = da_neg ? -a_l : a_l;
        db_mag      = db_neg ? -b_l : b_l;
        div_by_zero = (b_l == '0);
        // MIN / -1 falls out naturally: magnitude quotient 2^(XLEN-1) negates to itself.
        q_fix       = (da_neg ^ db_neg) ? -q_mag : q_mag;
        r_fix       = da_neg ? -r_mag : r_mag;
    end

    // cnt==1 in DIV is the prep cycle; a zero divisor skips the core and
    // goes straight to the sign-fix cycle when cnt reaches 0.
    assign core_start = (state == ST_DIV) && (cnt == CW'(1)) && !div_by_zero;
    assign fix_now    = (state == ST_DIV) && (div_by_zero ? (cnt == '0) : core_done);
    assign mul_last   = (state == ST_MUL) && (cnt == '0);

    muldiv_div_core #(
        .XLEN  (XLEN),
        .RADIX (DIV_RADIX)
    ) u_div_core (
        .clk       (clk),
        .resetn    (resetn),
        .abort     (flush),
        .start     (core_start),
        .dividend  (da_mag),
        .divisor   (db_mag),
        .done      (core_done),
        .quotient  (q_mag),
        .remainder (r_mag)
    );

    // Cycles spent in MUL/DIV minus one.
    always_comb begin
        cnt_init = CW'(MUL_LAT - 1);
        if (op_to_alu(op) == ALU_DIV) begin
            cnt_init = CW'(1);
        end else if (op_to_alu(op) == ALU_ACC) begin
`ifdef MULDIV_ACC_EN
            cnt_init = CW'(MUL_LAT);
`else
            cnt_init = '0;
`endif
        end
    end

    logic [2*XLEN-1:0] mul_res;
    always_comb begin
        mul_res = pipe[MUL_LAT-1];
        if (op_l[2]) begin
`ifdef MULDIV_ACC_EN
            mul_res = op_acc_sub(op_l) ? (hilo_l - pipe[MUL_LAT-1]) : (hilo_l + pipe[MUL_LAT-1]);
`else
            mul_res = hilo_l;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = (op_to_alu(op) == ALU_DIV) ? ST_DIV : ST_MUL;
            ST_MUL:  if (cnt == '0) state_n = ST_DONE;
            ST_DIV:  if (fix_now) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (flush) state_n = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt      <= '0;
            op_l     <= '0;
            a_l      <= '0;
            b_l      <= '0;
            hilo_l   <= '0;
            dz_r     <= 1'b0;
            hilo_out <= '0;
            for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
        end else begin
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
            if (accept) begin
                op_l    <= op;
                a_l     <= srca;
                b_l     <= srcb;
                hilo_l  <= hilo_in;
                pipe[0] <= prod;
                cnt     <= cnt_init;
            end else if (((state == ST_MUL) || (state == ST_DIV)) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (!flush) begin
                if (mul_last) begin
                    hilo_out <= mul_res;
                    dz_r     <= 1'b0;
                end
                if (fix_now) begin
                    hilo_out <= div_by_zero ? {a_l, {XLEN{1'b1}}} : {r_fix, q_fix};
                    dz_r     <= div_by_zero;
                end
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE);
    assign stall        = busy & ~result_valid;
    assign div_zero     = result_valid & dz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_LAT=3, DIV_RADIX=1).
// Expected results come from a behavioural model and are queued at issue, popped at result_valid.
// Covers reset, mul/div sign cases, divide-by-zero, MIN/-1, 1xx ops, flush, and held op_valid.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN      = 32;
    localparam int MUL_LAT   = 3;
    localparam int DIV_RADIX = 1;
    localparam int DIV_LAT   = XLEN / DIV_RADIX + 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic [63:0] hilo_in = '0;
    logic        busy, stall, result_valid, div_zero;
    logic [63:0] hilo_out;

    typedef struct packed {
        logic [63:0] hilo;
        logic        dz;
        logic [31:0] lat;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] last_hilo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN      (XLEN),
        .MUL_LAT   (MUL_LAT),
        .DIV_RADIX (DIV_RADIX)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .op_valid     (op_valid),
        .op           (op),
        .srca         (srca),
        .srcb         (srcb),
        .hilo_in      (hilo_in),
        .busy         (busy),
        .stall        (stall),
        .result_valid (result_valid),
        .hilo_out     (hilo_out),
        .div_zero     (div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [63:0] h);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p;
        int          qa, qb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = o[0] ? ({32'd0, a} * {32'd0, b}) : 64'(sa * sb);
        e.dz   = 1'b0;
        e.lat  = 32'(MUL_LAT);
        e.hilo = p;
        if (o[2:1] == 2'b01) begin
            e.lat = 32'(DIV_LAT);
            if (b == 32'd0) begin
                e.hilo = {a, 32'hFFFF_FFFF};
                e.dz   = 1'b1;
                e.lat  = 32'd2;
            end else if (o[0]) begin
                e.hilo = {a % b, a / b};
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.hilo = {32'd0, 32'h8000_0000};
            end else begin
                qa = int'(a);
                qb = int'(b);
                e.hilo = {32'(qa % qb), 32'(qa / qb)};
            end
        end else if (o[2]) begin
`ifdef MULDIV_ACC_EN
            e.lat  = 32'(MUL_LAT + 1);
            e.hilo = o[1] ? (h - p) : (h + p);
`else
            e.lat  = 32'd1;
            e.hilo = h;
`endif
        end
        return e;
    endfunction

    // Called #1 after a posedge with the DUT idle; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h);
        sb_q.push_back(model(o, a, b, h));
        op = o; srca = a; srcb = b; hilo_in = h;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_result(input logic jitter);
        int   cyc = 0;
        int   st = 0;
        logic seen = 1'b0;
        exp_t e;
        chk("busy_after_accept", 64'(busy), 64'd1);
        while (cyc < 200) begin
            if (result_valid) begin
                seen = 1'b1;
                break;
            end
            if (stall) st++;
            if (jitter) begin
                srca = $urandom;
                srcb = $urandom;
                hilo_in = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            chk("timeout", 64'(cyc), 64'(e.lat));
            return;
        end
        chk("latency", 64'(cyc), 64'(e.lat));
        chk("stall_cycles", 64'(st), 64'(e.lat));
        chk("hilo_out", hilo_out, e.hilo);
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("stall_in_done", 64'(stall), 64'd0);
        last_hilo = e.hilo;
        @(posedge clk); #1;
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("pulse_single", 64'(result_valid), 64'd0);
        chk("hilo_hold", hilo_out, last_hilo);
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h);
        issue(o, a, b, h);
        wait_result(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rv_seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_hilo", hilo_out, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Multiply
        run(MULDIV_OP_MULT,  32'hFFFF_FFFD, 32'd7, 64'd0);
        run(MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        run(MULDIV_OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 64'd0);
        run(MULDIV_OP_MULT,  32'hFFFF_FFF0, 32'hFFFF_FFF0, 64'd0);
        // Divide
        run(MULDIV_OP_DIV,   32'hFFFF_FFF9, 32'd2, 64'd0);
        run(MULDIV_OP_DIVU,  32'd7, 32'd0, 64'd0);
        run(MULDIV_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
        run(MULDIV_OP_DIV,   32'hFFFF_FFF9, 32'd0, 64'd0);
        run(MULDIV_OP_DIV,   32'd100, 32'hFFFF_FFF9, 64'd0);
        run(MULDIV_OP_DIVU,  32'hFFFF_FFFF, 32'd10, 64'd0);
        // Accumulate / pass-through ops
        run(MULDIV_OP_MADD,  32'd2, 32'd3, 64'd1);
        run(MULDIV_OP_MSUBU, 32'd1, 32'd1, 64'd0);
        run(MULDIV_OP_MSUB,  32'hFFFF_FFFE, 32'd5, 64'h0000_0001_0000_0000);
        run(MULDIV_OP_MADDU, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        // Random mix
        for (int i = 0; i < 6; i++) begin
            run(3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 40)), {$urandom, $urandom});
        end

        // Flush mid-divide: no pulse, idle next cycle, hilo_out unchanged.
        op = MULDIV_OP_DIVU; srca = 32'd1000; srcb = 32'd3; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        rv_seen = 0;
        repeat (9) begin
            if (result_valid) rv_seen++;
            @(posedge clk); #1;
        end
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy_after", 64'(busy), 64'd0);
        repeat (40) begin
            if (result_valid) rv_seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_pulse", 64'(rv_seen), 64'd0);
        chk("flush_hilo_hold", hilo_out, last_hilo);
        run(MULDIV_OP_MULT, 32'd12345, 32'hFFFF_FF00, 64'd0);

        // Flush together with a request in IDLE drops the request.
        op = MULDIV_OP_MULT; srca = 32'd5; srcb = 32'd5; op_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", 64'(busy), 64'd0);
        rv_seen = 0;
        repeat (5) begin
            if (result_valid) rv_seen++;
            @(posedge clk); #1;
        end
        chk("flush_idle_no_pulse", 64'(rv_seen), 64'd0);

        // op_valid held with changing operands: one result from the first
        // operands, then the second request is taken after DONE.
        issue(MULDIV_OP_DIVU, 32'd100, 32'd7, 64'd0);
        op_valid = 1'b1;
        wait_result(1'b1);
        op = MULDIV_OP_DIV; srca = 32'hFFFF_FF9C; srcb = 32'd7;
        sb_q.push_back(model(MULDIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 64'd0));
        @(posedge clk); #1;
        op_valid = 1'b0;
        wait_result(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
